sram_stream_fifo: RTL
=====================

SRAM_STREAM_FIFO -- requirements
Module: sram_stream_fifo

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, SRAM word width.
REQ-002 The block SHALL have parameter ADDR_W, default 15, SRAM address width; depth = 2**ADDR_W = 32768 words.
REQ-003 The block SHALL have port clk, in, 1, single clock for all logic and both SRAM ports (CKA = CKB = clk).
REQ-004 The block SHALL have port rst, in, 1, synchronous active-high reset.
REQ-005 The block SHALL have port flush, in, 1, synchronous clear of all contents.
REQ-006 The block SHALL have ports in_valid in 1, in_ready out 1, in_data in DATA_W: the write stream.
REQ-007 The block SHALL have ports out_valid out 1, out_ready in 1, out_data out DATA_W: the read stream.
REQ-008 The block SHALL have ports count out ADDR_W+1, full out 1, empty out 1.
REQ-009 The block SHALL have SRAM port A outputs sram_csa 1, sram_oea 1, sram_wean 1, sram_aa ADDR_W, sram_dia DATA_W (write-only port).
REQ-010 The block SHALL have SRAM port B outputs sram_csb 1, sram_oeb 1, sram_webn 1, sram_ab ADDR_W, sram_dib DATA_W, and input sram_dob DATA_W (read-only port).

Function
REQ-011 SRAM model: CS active high, WE active low, OE active high; a read is sampled at a clk edge and its data is valid on DO throughout the following cycle.
REQ-012 in_ready SHALL equal (count < 2**ADDR_W) and not flush; a push occurs when in_valid and in_ready are both high.
REQ-013 On a push, in the same cycle the block SHALL combinationally drive sram_csa=1, sram_wean=0, sram_aa=wr_ptr, sram_dia=in_data; otherwise sram_csa=0, sram_wean=1.
REQ-014 sram_oea SHALL be 0, sram_webn SHALL be 1, and sram_dib SHALL be 0 at all times.
REQ-015 wr_ptr and rd_ptr SHALL be ADDR_W-bit counters that increment per push or read-issue and wrap from 2**ADDR_W-1 to 0.
REQ-016 sram_cnt, the words written but not yet read-issued, SHALL count a push as available from the cycle after the push, so a write and a read never address the same word in one cycle.
REQ-017 The output stage SHALL be a 2-entry register buffer (ob) plus a 1-bit in-flight flag.
REQ-018 A read SHALL issue when sram_cnt > 0 and ob occupancy plus in-flight plus (ob nonempty ? 0 : 0) < 2 with pop credit: the issue condition is (ob_cnt + inflight - pop) < 2, where pop = out_valid and out_ready.
REQ-019 On issue the block SHALL drive sram_csb=1, sram_oeb=1, sram_ab=rd_ptr, and set inflight; otherwise sram_csb=0, sram_oeb=0.
REQ-020 When inflight is set, the block SHALL capture sram_dob into ob at the end of that cycle.
REQ-021 out_valid SHALL be (ob_cnt != 0) and not flush, and out_data SHALL be the ob head, registered with no combinational path from sram_dob.
REQ-022 Ordering SHALL be strict FIFO; the first push accepted in cycle N into an empty block SHALL appear with out_valid=1 in cycle N+3, and steady-state throughput SHALL be 1 word/cycle with out_ready held high.
REQ-023 count SHALL equal sram_cnt + inflight + ob_cnt plus pending push; it SHALL increment by 1 per push, decrement by 1 per pop, and stay unchanged on a simultaneous push and pop.
REQ-024 empty SHALL equal (count == 0); full SHALL equal (count == 2**ADDR_W).
REQ-025 When full with a pop in the same cycle, in_ready SHALL remain 0 in that cycle (no bypass); it SHALL rise the next cycle.
REQ-026 Holding out_ready low SHALL stall reads after ob fills; no word SHALL be lost or duplicated, and out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-027 flush SHALL override push, pop and read-issue in its cycle (in_ready=0, out_valid=0, sram_csa=0, sram_csb=0), and the next cycle SHALL show the reset state with any in-flight read data discarded.

Reset
REQ-028 On rst, the block SHALL clear wr_ptr, rd_ptr, sram_cnt, inflight, ob_cnt, and ob contents to 0.
REQ-029 In the rst cycle and the cycle after it, the block SHALL drive in_ready=0 during rst, out_valid=0, count=0, empty=1, full=0, sram_csa=0, sram_wean=1, sram_csb=0, sram_oeb=0, sram_aa=0, sram_ab=0, sram_dia=0.
REQ-030 rst SHALL take priority over flush and all handshakes, including reset asserted mid-stream.

Verification
REQ-031 Latency: push 0x1234 in cycle N, out_ready=1 -> sram_csa in N, sram_csb with ab=0 in N+1, out_valid with out_data=0x1234 in N+3, empty in N+4.
REQ-032 Wrap: push 32768 words with value i -> full=1, count=32768, in_ready=0; pop 1 and push 0xBEEF -> wr_ptr wraps to 0; the drain order is 1..32767 followed by 0xBEEF.
REQ-033 Backpressure: 10 words with out_ready=0 -> exactly 2 reads issue, then sram_csb stays 0 and out_data is stable at word 0; release -> words 0..9 in order, one per cycle.
REQ-034 Simultaneous: a continuous stream with in_valid=out_ready=1 -> count constant after fill, and no gaps in out_valid after the 3-cycle start-up.
REQ-035 Flush: flush asserted with 5 words stored and a read in flight -> next cycle count=0, empty=1, out_valid=0; a following push of 0xA5A5 reappears first after 3 cycles.
REQ-036 Reset mid-operation: rst during full-rate streaming -> the REQ-029 values in the rst cycle and the cycle after, with no sram_csa or sram_csb pulse.

Source files
------------

// File: rtl/sram_stream_fifo.sv
// sram_stream_fifo: streaming FIFO that keeps its contents in an external
// dual-port SRAM (port A writes, port B reads) and hides the one-cycle SRAM
// read latency behind a 2-entry output register buffer. Everything, both
// SRAM ports included, runs on the single clock clk.
//
// Handshake rule for both streams: a word moves across a port in a cycle
// exactly when valid and ready are both high in that cycle. valid never
// waits for ready, in_ready never looks at in_valid, and a producer keeps
// valid and data steady until the word has been taken.
module sram_stream_fifo #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  // write stream
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  // read stream
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  // fill status
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  // SRAM port A (write only)
  output logic              sram_csa,
  output logic              sram_oea,
  output logic              sram_wean,
  output logic [ADDR_W-1:0] sram_aa,
  output logic [DATA_W-1:0] sram_dia,
  // SRAM port B (read only)
  output logic              sram_csb,
  output logic              sram_oeb,
  output logic              sram_webn,
  output logic [ADDR_W-1:0] sram_ab,
  output logic [DATA_W-1:0] sram_dib,
  input  logic [DATA_W-1:0] sram_dob
);

  localparam logic [ADDR_W:0]   DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE = 1;
  localparam logic [ADDR_W-1:0] PTR_ONE = 1;

  // SRAM pointers; they wrap naturally at 2**ADDR_W
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  // words written to the SRAM but not yet read-issued
  logic [ADDR_W:0]   sram_cnt;
  // total words held: sram_cnt + inflight + ob_cnt
  logic [ADDR_W:0]   count_q;
  // a port B read was issued last cycle; its data is on sram_dob now
  logic              inflight;
  // 2-entry output buffer, head/tail indices and occupancy
  logic [DATA_W-1:0] ob_mem [2];
  logic              ob_head;
  logic              ob_tail;
  logic [1:0]        ob_cnt;

  logic              push;
  logic              pop;
  logic              issue;
  logic [2:0]        ob_occ;
  logic [2:0]        ob_room;

  // Stream handshakes; rst and flush mask both sides in their cycle
  assign in_ready  = !rst && !flush && (count_q != DEPTH);
  assign out_valid = !rst && !flush && (ob_cnt != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = ob_mem[ob_head];

  // A read may issue only if its data will have a buffer slot when it lands,
  // counting the slot freed by a pop in this same cycle
  assign ob_occ  = {1'b0, ob_cnt} + {2'b00, inflight};
  assign ob_room = {2'b00, pop} + 3'd2;
  assign issue   = !rst && !flush && (sram_cnt != '0) && (ob_occ < ob_room);

  // Status; count reads as zero in the reset cycle itself
  assign count = rst ? '0 : count_q;
  assign empty = (count == '0);
  assign full  = (count == DEPTH);

  // SRAM port A: one write per accepted push, bus parked at zero otherwise
  assign sram_csa  = push;
  assign sram_wean = !push;
  assign sram_oea  = 1'b0;
  assign sram_aa   = push ? wr_ptr : '0;
  assign sram_dia  = push ? in_data : '0;

  // SRAM port B: one read per issue, never written
  assign sram_csb  = issue;
  assign sram_oeb  = issue;
  assign sram_webn = 1'b1;
  assign sram_ab   = issue ? rd_ptr : '0;
  assign sram_dib  = '0;

  // Pointer, occupancy and output buffer state; rst and flush both clear it
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      sram_cnt  <= '0;
      count_q   <= '0;
      inflight  <= 1'b0;
      ob_head   <= 1'b0;
      ob_tail   <= 1'b0;
      ob_cnt    <= 2'd0;
      ob_mem[0] <= '0;
      ob_mem[1] <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (issue) rd_ptr <= rd_ptr + PTR_ONE;
      sram_cnt <= sram_cnt + (push ? CNT_ONE : '0) - (issue ? CNT_ONE : '0);
      count_q  <= count_q + (push ? CNT_ONE : '0) - (pop ? CNT_ONE : '0);
      inflight <= issue;
      if (inflight) begin
        ob_mem[ob_tail] <= sram_dob;
        ob_tail         <= ~ob_tail;
      end
      if (pop) ob_head <= ~ob_head;
      ob_cnt <= ob_cnt + {1'b0, inflight} - {1'b0, pop};
    end
  end

endmodule
